// File: rtl/mem_responder_if.sv
// mem_responder_if: cpu byte bus plus input-byte and output-byte stream handshakes
interface mem_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    modport master (
        output mem_a, mem_wr, mem_dout, in_valid, in_data, out_ready,
        input  mem_din, in_ready, out_valid, out_data
    );
    modport slave (
        input  mem_a, mem_wr, mem_dout, in_valid, in_data, out_ready,
        output mem_din, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 128KB RAM plus I/O (input byte, output FIFO, cycle counter, stop flag) at 0x30000.
// Optional MEM_OOR_TRAP_EN traps 0x20000..0x2FFFF and adds the sticky oor_err output.
module mem_responder #(
    parameter int RAM_AW   = 17,
    parameter int OFIFO_AW = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    mem_responder_if.slave bus,
    output logic         prog_stop,
    output logic         ofifo_ovf
`ifdef MEM_OOR_TRAP_EN
    ,
    output logic         oor_err
`endif
);
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] fifo [2**OFIFO_AW];
    logic [17:0] a;
    logic [15:0] off;
    logic is_io, is_oor, rd, io_wr, stop_wr, ram_we;
    logic push_req, push, pop, full;
    logic [7:0] push_data, io_rdata, rdata;
    logic [7:0] mem_din_d, mem_din_q, out_data_d, out_data_q;
    logic [31:0] cnt_d, cnt_q, snap_d, snap_q;
    logic [OFIFO_AW:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic out_valid_d, out_valid_q, prog_stop_d, prog_stop_q, ovf_d, ovf_q;
`ifdef MEM_OOR_TRAP_EN
    logic oor_err_d, oor_err_q;
`endif
    logic unused_ok;
    assign a = bus.mem_a[17:0];
    assign unused_ok = ^bus.mem_a[31:18];
    always_comb begin
        off = a[15:0];
        is_io = a[17:16] == 2'b11;
`ifdef MEM_OOR_TRAP_EN
        is_oor = a[17:16] == 2'b10;
        oor_err_d = oor_err_q | is_oor;
`else
        is_oor = 1'b0;
`endif
        rd = !bus.mem_wr;
        io_wr = bus.mem_wr && is_io;
        ram_we = bus.mem_wr && !is_io && !is_oor;
        io_rdata = (off == 16'h0) ? (bus.in_valid ? bus.in_data : 8'h00) :
                   (off == 16'h4) ? cnt_q[7:0] :
                   (off == 16'h5) ? snap_q[15:8] :
                   (off == 16'h6) ? snap_q[23:16] :
                   (off == 16'h7) ? snap_q[31:24] : 8'h00;
        rdata = is_io ? io_rdata : is_oor ? 8'hFF : ram[a[RAM_AW-1:0]];
        mem_din_d = rd ? rdata : mem_din_q;
        bus.in_ready = !rst_in && rd && is_io && off == 16'h0 && bus.in_valid;
        // reading byte 0 latches the whole counter so bytes 1..3 stay coherent
        snap_d = (rd && is_io && off == 16'h4) ? cnt_q : snap_q;
        cnt_d = prog_stop_q ? cnt_q : cnt_q + 32'd1;
        stop_wr = io_wr && off == 16'h4;
        prog_stop_d = prog_stop_q | stop_wr;
        push_req = stop_wr || (io_wr && off == 16'h0 && bus.mem_dout != 8'h00);
        push_data = stop_wr ? 8'h00 : bus.mem_dout;
        full = wr_ptr_q == {~rd_ptr_q[OFIFO_AW], rd_ptr_q[OFIFO_AW-1:0]};
        pop = out_valid_q && bus.out_ready;
        push = push_req && (!full || pop);
        ovf_d = ovf_q | (push_req && full && !pop);
        wr_ptr_d = wr_ptr_q + (OFIFO_AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (OFIFO_AW+1)'(pop);
        out_valid_d = wr_ptr_d != rd_ptr_d;
        // the new head may be the byte being written this edge, not yet in storage
        out_data_d = !out_valid_d ? 8'h00 :
                     (push && wr_ptr_q == rd_ptr_d) ? push_data : fifo[rd_ptr_d[OFIFO_AW-1:0]];
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_q   <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            cnt_q       <= 32'd0;
            snap_q      <= 32'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            prog_stop_q <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef MEM_OOR_TRAP_EN
            oor_err_q   <= 1'b0;
`endif
        end else begin
            mem_din_q   <= mem_din_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            prog_stop_q <= prog_stop_d;
            ovf_q       <= ovf_d;
`ifdef MEM_OOR_TRAP_EN
            oor_err_q   <= oor_err_d;
`endif
        end
    end
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[a[RAM_AW-1:0]] <= bus.mem_dout;
        if (push) fifo[wr_ptr_q[OFIFO_AW-1:0]] <= push_data;
    end
    assign bus.mem_din   = mem_din_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign prog_stop     = prog_stop_q;
    assign ofifo_ovf     = ovf_q;
`ifdef MEM_OOR_TRAP_EN
    assign oor_err       = oor_err_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random bus traffic checked against a queue/array reference model
module tb_mem_responder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic prog_stop, ofifo_ovf;
    always #5 clk_in = ~clk_in;
    mem_responder_if bus();
`ifdef MEM_OOR_TRAP_EN
    logic oor_err;
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif
    mem_responder #(.RAM_AW(17), .OFIFO_AW(4)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus),
        .prog_stop(prog_stop),
        .ofifo_ovf(ofifo_ovf)
`ifdef MEM_OOR_TRAP_EN
        ,
        .oor_err(oor_err)
`endif
    );
    logic [7:0] ram_m [int];
    int wr_addrs[$];
    logic [7:0] q[$];
    logic [7:0] popped[$];
    logic [7:0] exp_din;
    logic [31:0] cnt_m, snap_m;
    logic stop_m, ovf_m, oor_m, ordy_g;
    int checks = 0;
    int errors = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic wr, input logic [31:0] addr, input logic [7:0] d,
                        input logic iv, input logic [7:0] idat, input logic ordy);
        logic [17:0] a;
        logic [15:0] off;
        logic io, oor, pop, push_req;
        logic [7:0] rv, pd;
        @(negedge clk_in);
        check("mem_din", bus.mem_din, exp_din);
        check("out_valid", bus.out_valid, q.size() != 0);
        check("out_data", bus.out_data, q.size() != 0 ? q[0] : 8'h00);
        check("prog_stop", prog_stop, stop_m);
        check("ofifo_ovf", ofifo_ovf, ovf_m);
`ifdef MEM_OOR_TRAP_EN
        check("oor_err", oor_err, oor_m);
`endif
        bus.mem_wr = wr; bus.mem_a = addr; bus.mem_dout = d;
        bus.in_valid = iv; bus.in_data = idat; bus.out_ready = ordy;
        a = addr[17:0];
        off = a[15:0];
        io = a[17:16] == 2'b11;
        oor = OOR && a[17:16] == 2'b10;
        rv = 8'h00;
        if (io) begin
            case (off)
                16'h0: rv = iv ? idat : 8'h00;
                16'h4: rv = cnt_m[7:0];
                16'h5: rv = snap_m[15:8];
                16'h6: rv = snap_m[23:16];
                16'h7: rv = snap_m[31:24];
                default: rv = 8'h00;
            endcase
        end else if (oor) rv = 8'hFF;
        else if (ram_m.exists(int'(a[16:0]))) rv = ram_m[int'(a[16:0])];
        #1;
        check("in_ready", bus.in_ready, !wr && io && off == 16'h0 && iv);
        pop = q.size() != 0 && ordy;
        push_req = wr && io && ((off == 16'h0 && d != 8'h00) || off == 16'h4);
        pd = (off == 16'h4) ? 8'h00 : d;
        @(posedge clk_in);
        if (!wr) begin
            exp_din = rv;
            if (io && off == 16'h4) snap_m = cnt_m;
        end
        if (oor) oor_m = 1'b1;
        if (pop) popped.push_back(q.pop_front());
        if (push_req) begin
            if (q.size() < 16) q.push_back(pd);
            else ovf_m = 1'b1;
        end
        if (wr && !io && !oor) ram_m[int'(a[16:0])] = d;
        if (!stop_m) cnt_m++;
        if (wr && io && off == 16'h4) stop_m = 1'b1;
    endtask
    task automatic wr_b(input logic [31:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0, 8'h00, ordy_g);
    endtask
    task automatic rd_b(input logic [31:0] a);
        step(1'b0, a, 8'h00, 1'b0, 8'h00, ordy_g);
    endtask
    task automatic idle(input int n);
        repeat (n) step(1'b1, 32'h3000C, 8'h00, 1'b0, 8'h00, ordy_g);
    endtask
    // reset is asserted while a RAM read is on the bus, so that read must be discarded
    task automatic reset_dut();
        @(negedge clk_in);
        rst_in = 1'b1;
        bus.mem_wr = 1'b0; bus.mem_a = 32'h100; bus.mem_dout = 8'h00;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        exp_din = 8'h00; q.delete(); stop_m = 1'b0; ovf_m = 1'b0; oor_m = 1'b0;
        cnt_m = 32'd0; snap_m = 32'd0;
    endtask
    initial begin
        ordy_g = 1'b1;
        reset_dut();
        wr_b(32'h00100, 8'hA5);
        rd_b(32'h00100);
        idle(1);
        check("t1_read", bus.mem_din, 8'hA5);
        step(1'b0, 32'h30000, 8'h00, 1'b1, 8'h41, 1'b1);
        idle(1);
        check("t2_in_byte", bus.mem_din, 8'h41);
        step(1'b0, 32'h30000, 8'h00, 1'b0, 8'h55, 1'b1);
        idle(1);
        check("t2_no_input", bus.mem_din, 8'h00);
        popped.delete();
        wr_b(32'h30000, 8'h48);
        wr_b(32'h30000, 8'h00);
        wr_b(32'h30000, 8'h69);
        idle(3);
        check("t3_count", popped.size(), 2);
        check("t3_b0", popped.size() > 0 ? popped[0] : 8'hxx, 8'h48);
        check("t3_b1", popped.size() > 1 ? popped[1] : 8'hxx, 8'h69);
        ordy_g = 1'b0;
        for (int i = 0; i < 17; i++) wr_b(32'h30000, 8'(i + 1));
        idle(1);
        check("t4_ovf", ofifo_ovf, 1'b1);
        popped.delete();
        step(1'b1, 32'h30000, 8'hEE, 1'b0, 8'h00, 1'b1);
        ordy_g = 1'b1;
        idle(20);
        check("t4_drain_count", popped.size(), 17);
        for (int i = 0; i < 16; i++)
            check("t4_order", i < popped.size() ? popped[i] : 8'hxx, 8'(i + 1));
        check("t4_full_push", popped.size() > 16 ? popped[16] : 8'hxx, 8'hEE);
        wr_addrs.push_back(32'h100);
        for (int i = 0; i < 300; i++) begin
            int k;
            logic [31:0] ra;
            k = $urandom_range(0, 5);
            ordy_g = 1'($urandom_range(0, 1));
            case (k)
                0, 1: begin
                    ra = {15'd0, 17'($urandom)};
                    wr_addrs.push_back(int'(ra));
                    wr_b(ra, 8'($urandom));
                end
                2: rd_b(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
                3: step(1'b0, 32'h30000, 8'h00, 1'($urandom_range(0, 1)), 8'($urandom), ordy_g);
                4: wr_b(32'h30000, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
                default: rd_b(32'h30004 + 32'($urandom_range(0, 4)));
            endcase
        end
        ordy_g = 1'b0;
        wr_b(32'h30000, 8'h77);
        reset_dut();
        ordy_g = 1'b1;
        idle(1);
        check("rst_din", bus.mem_din, 8'h00);
        rd_b(32'h00100);
        idle(1);
        check("ram_kept", bus.mem_din, ram_m[32'h100]);
        idle(1000);
        rd_b(32'h30004);
        idle(3);
        rd_b(32'h30005);
        rd_b(32'h30006);
        rd_b(32'h30007);
        idle(1);
        check("t5_snap_hi", bus.mem_din, snap_m[31:24]);
        popped.delete();
        wr_b(32'h30004, 8'h01);
        idle(2);
        check("t5_stop", prog_stop, 1'b1);
        check("t5_term", popped.size() == 1 ? popped[0] : 8'hxx, 8'h00);
        wr_b(32'h30004, 8'h01);
        idle(2);
        check("t5_term_again", popped.size(), 2);
        rd_b(32'h30004);
        idle(50);
        rd_b(32'h30004);
        rd_b(32'h30005);
        idle(1);
        check("t5_frozen", bus.mem_din, cnt_m[15:8]);
`ifdef MEM_OOR_TRAP_EN
        rd_b(32'h24000);
        idle(1);
        check("t6_oor_read", bus.mem_din, 8'hFF);
        check("t6_oor_err", oor_err, 1'b1);
        wr_b(32'h00010, 8'h33);
        wr_b(32'h20010, 8'h5A);
        rd_b(32'h00010);
        idle(1);
        check("t6_oor_drop", bus.mem_din, 8'h33);
`else
        wr_b(32'h20010, 8'h5A);
        rd_b(32'h00010);
        idle(1);
        check("t6_alias", bus.mem_din, 8'h5A);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
